lsu_mem_master: RTL and testbench
=================================

# lsu_mem_master

Load/store initiator between the RV32I core datapath and the word-organised data memory wrapper. It accepts one load or store per transaction from the core and issues a single-cycle `request` pulse with byte mask, word address and replicated store data. It then waits for the memory's registered `valid` response and returns sign/zero-extended load data with a `done` pulse. Misaligned or illegal accesses and response timeouts are reported through `err` without hanging the core.

## Interface
- `ADDR_W`, 8: memory word-address width; `mem_address = core_addr[ADDR_W+1:2]`.
- `TIMEOUT`, 15: maximum WAIT cycles without `mem_valid` before abort; range 1..255.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `core_req`  in  1  transaction strobe; sampled only in IDLE.
- `core_we`  in  1  1 = store, 0 = load.
- `core_funct3`  in  3  RV32I width code (LB 0, LH 1, LW 2, LBU 4, LHU 5; SB 0, SH 1, SW 2).
- `core_addr`  in  32  byte address.
- `core_wdata`  in  32  store data; low byte/half used for SB/SH.
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  qualifies `done`: misaligned, illegal funct3 or timeout.
- `rdata`  out  32  extended load data; valid while `done` is high and held until the next `done`.
- `mem_request`  out  1  one-cycle request pulse.
- `mem_we_re`  out  1  1 = write.
- `mem_mask`  out  4  byte enables.
- `mem_address`  out  ADDR_W  word address.
- `mem_data_in`  out  32  aligned store data.
- `mem_valid`  in  1  response, one cycle after `mem_request`.
- `mem_data_out`  in  32  read word; valid while `mem_valid` is high.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - `core_req`=1 latches `we`, `funct3`, `addr` and `wdata`.
  - Legal access: go to ISSUE.
  - Misaligned or illegal access: go to RESP with `err` set and no memory access.
- **ISSUE**
  - `mem_request`=1 for exactly this cycle; mask, address and data are driven from the latched values.
  - Go to WAIT and clear the timeout counter.
- **WAIT**
  - `mem_valid`=1: capture the extended load data into `rdata` (stores leave `rdata` unchanged) and go to RESP with `err`=0.
  - Otherwise the counter increments. When the counter reaches `TIMEOUT`, go to RESP with `err`=1 and leave `rdata` unchanged.
- **RESP**: `done`=1 and `err` per the latched flag, then go to IDLE.
- Misalignment rules:
  - Halfword with `addr[0]`=1 is misaligned.
  - Word with `addr[1:0]`≠0 is misaligned.
  - Illegal funct3: loads 3, 6, 7; stores 3–7.
- Masks (`o` = `addr[1:0]`):
  - Byte: 4'b0001<<o.
  - Half: 4'b0011<<o.
  - Word: 4'b1111.
  - Loads drive the same mask.
- Store data: SB replicates `wdata[7:0]` ×4, SH replicates `wdata[15:0]` ×2, SW passes `wdata` through.
- Load data: `mem_data_out >> (8*o)`, then sign-extend (LB, LH) or zero-extend (LBU, LHU) from bit 7 or 15; LW passes the word through.
- `mem_valid` outside WAIT is ignored.
- `core_req` outside IDLE is ignored; the core must wait for `done`.

## Timing
- All outputs are registered.
- Reset values: state IDLE; `busy`, `done`, `err`, `mem_request`, `mem_we_re` = 0; `mem_mask`, `mem_address`, `mem_data_in`, `rdata` = 0.
- Nominal legal access:
  - `core_req` sampled at edge 0.
  - `mem_request` high in cycle 1.
  - `mem_valid` high in cycle 2.
  - `done` high in cycle 3.
  - Latency is 3 cycles.
- Back-to-back: the next accepted `core_req` is the one sampled in the IDLE cycle after RESP. Peak throughput is one access per 4 cycles.
- Error access: `done`/`err` is high in cycle 1 after acceptance.
- Timeout: `done`/`err` is high `TIMEOUT`+2 cycles after the `mem_request` cycle.
- Reset asserted mid-transaction: immediate return to IDLE with all outputs at reset values. A pending memory response is dropped.
- Memory-side signals other than `mem_request` hold their last values after ISSUE; the memory acts only on `mem_request`.

## Structure
- Shared package `lsu_pkg`:
  - funct3 width constants.
  - state enum.
  - `MASK_B`/`MASK_H`/`MASK_W` base constants.
- Sub-module `lsu_align`, purely combinational:
  - Inputs: funct3, offset, wdata, rdata_raw.
  - Outputs: mask, store data, extended load data, misalign/illegal flag.
- The top level holds the FSM, latch registers and timeout counter.

## Test plan
- SW addr 0x10, wdata 0xDEADBEEF, then LW addr 0x10 -> `mem_address`=4, mask 4'b1111, `done` 3 cycles after `core_req`, `rdata`=0xDEADBEEF, `err`=0.
- SB addr 0x13, wdata 0x000000A5 -> mask 4'b1000, `mem_data_in`=0xA5A5A5A5. Then LB addr 0x13 -> `rdata`=0xFFFFFFA5; LBU -> 0x000000A5.
- SH addr 0x22, wdata 0x8001 -> mask 4'b1100, `mem_data_in`=0x80018001. Then LH addr 0x22 -> `rdata`=0xFFFF8001.
- LW addr 0x11 and SH addr 0x01 -> no `mem_request`; `done`=`err`=1 one cycle after acceptance.
- Memory model that never returns `mem_valid`, `TIMEOUT`=15 -> `done`=`err`=1 exactly 17 cycles after `mem_request`, `busy` drops the following cycle.
- Reset asserted during WAIT, then `mem_valid` arrives -> outputs at reset values, no `done`; the next LW completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store memory master.
package lsu_pkg;

    localparam int unsigned FUNCT3_W = 3;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned BE_W     = 4;
    localparam int unsigned CNT_W    = 8;

    localparam logic [FUNCT3_W-1:0] F3_B  = 3'd0;
    localparam logic [FUNCT3_W-1:0] F3_H  = 3'd1;
    localparam logic [FUNCT3_W-1:0] F3_W  = 3'd2;
    localparam logic [FUNCT3_W-1:0] F3_BU = 3'd4;
    localparam logic [FUNCT3_W-1:0] F3_HU = 3'd5;

    localparam logic [BE_W-1:0] MASK_B = 4'b0001;
    localparam logic [BE_W-1:0] MASK_H = 4'b0011;
    localparam logic [BE_W-1:0] MASK_W = 4'b1111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment: mask/store replication, load extraction/extension, access legality.
module lsu_align
    import lsu_pkg::*;
(
    input  logic                we,
    input  logic [FUNCT3_W-1:0] funct3,
    input  logic [1:0]          offset,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W-1:0]   rdata_raw,
    output logic [BE_W-1:0]     mask_c,
    output logic [DATA_W-1:0]   store_data_c,
    output logic [DATA_W-1:0]   load_data_c,
    output logic                bad_c
);

    logic [DATA_W-1:0] shifted;
    logic              illegal;
    logic              misaligned;

    // Lane selection and extension for the addressed byte/half/word.
    always_comb begin
        shifted      = rdata_raw >> {offset, 3'b000};
        mask_c       = MASK_W;
        store_data_c = wdata;
        load_data_c  = shifted;

        case (funct3[1:0])
            2'd0: begin
                mask_c       = MASK_B << offset;
                store_data_c = {4{wdata[7:0]}};
            end
            2'd1: begin
                mask_c       = MASK_H << offset;
                store_data_c = {2{wdata[15:0]}};
            end
            default: ;
        endcase

        case (funct3)
            F3_B:    load_data_c = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    load_data_c = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   load_data_c = {24'h000000, shifted[7:0]};
            F3_HU:   load_data_c = {16'h0000, shifted[15:0]};
            default: load_data_c = shifted;
        endcase

        illegal    = we ? (funct3 > F3_W) : ((funct3 == 3'd3) || (funct3 >= 3'd6));
        misaligned = ((funct3[1:0] == 2'd1) && offset[0]) ||
                     ((funct3[1:0] == 2'd2) && (offset != 2'd0));
        bad_c      = illegal | misaligned;
    end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store initiator: one core access -> one memory request, with timeout and error reporting.
module lsu_mem_master
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                core_req,
    input  logic                core_we,
    input  logic [2:0]          core_funct3,
    input  logic [31:0]         core_addr,
    input  logic [31:0]         core_wdata,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [31:0]         rdata,
    output logic                mem_request,
    output logic                mem_we_re,
    output logic [3:0]          mem_mask,
    output logic [ADDR_W-1:0]   mem_address,
    output logic [31:0]         mem_data_in,
    input  logic                mem_valid,
    input  logic [31:0]         mem_data_out
);

    state_t              state_q, state_d;
    logic                we_q, we_d;
    logic [FUNCT3_W-1:0] funct3_q, funct3_d;
    logic [1:0]          off_q, off_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic                busy_d, done_d, err_d, mem_request_d, mem_we_re_d;
    logic [31:0]         rdata_d, mem_data_in_d;
    logic [3:0]          mem_mask_d;
    logic [ADDR_W-1:0]   mem_address_d;

    logic                a_we;
    logic [FUNCT3_W-1:0] a_funct3;
    logic [1:0]          a_off;
    logic [3:0]          a_mask;
    logic [31:0]         a_store, a_load;
    logic                a_bad;
    logic                unused_addr_bits;

    assign unused_addr_bits = ^core_addr[31:ADDR_W+2];

    // Alignment looks at the live request in IDLE and at the latched access afterwards.
    assign a_we     = (state_q == S_IDLE) ? core_we          : we_q;
    assign a_funct3 = (state_q == S_IDLE) ? core_funct3      : funct3_q;
    assign a_off    = (state_q == S_IDLE) ? core_addr[1:0]   : off_q;

    lsu_align u_align (
        .we           (a_we),
        .funct3       (a_funct3),
        .offset       (a_off),
        .wdata        (core_wdata),
        .rdata_raw    (mem_data_out),
        .mask_c       (a_mask),
        .store_data_c (a_store),
        .load_data_c  (a_load),
        .bad_c        (a_bad)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_d       = state_q;
        we_d          = we_q;
        funct3_d      = funct3_q;
        off_d         = off_q;
        cnt_d         = cnt_q;
        err_d         = 1'b0;
        mem_request_d = 1'b0;
        rdata_d       = rdata;
        mem_we_re_d   = mem_we_re;
        mem_mask_d    = mem_mask;
        mem_address_d = mem_address;
        mem_data_in_d = mem_data_in;

        case (state_q)
            S_IDLE: begin
                if (core_req) begin
                    we_d     = core_we;
                    funct3_d = core_funct3;
                    off_d    = core_addr[1:0];
                    if (a_bad) begin
                        state_d = S_RESP;
                        err_d   = 1'b1;
                    end else begin
                        state_d       = S_ISSUE;
                        mem_request_d = 1'b1;
                        mem_we_re_d   = core_we;
                        mem_mask_d    = a_mask;
                        mem_address_d = core_addr[ADDR_W+1:2];
                        mem_data_in_d = a_store;
                    end
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
                cnt_d   = '0;
            end
            S_WAIT: begin
                if (mem_valid) begin
                    if (!we_q) begin
                        rdata_d = a_load;
                    end
                    state_d = S_RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                    state_d = S_RESP;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        done_d = (state_d == S_RESP);
        busy_d = (state_d != S_IDLE);
    end

    // State, latched access and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            we_q        <= 1'b0;
            funct3_q    <= '0;
            off_q       <= '0;
            cnt_q       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            rdata       <= '0;
            mem_request <= 1'b0;
            mem_we_re   <= 1'b0;
            mem_mask    <= '0;
            mem_address <= '0;
            mem_data_in <= '0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            funct3_q    <= funct3_d;
            off_q       <= off_d;
            cnt_q       <= cnt_d;
            busy        <= busy_d;
            done        <= done_d;
            err         <= err_d;
            rdata       <= rdata_d;
            mem_request <= mem_request_d;
            mem_we_re   <= mem_we_re_d;
            mem_mask    <= mem_mask_d;
            mem_address <= mem_address_d;
            mem_data_in <= mem_data_in_d;
        end
    end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Scoreboard bench for lsu_mem_master with a byte-masked word memory model.
module tb_lsu_mem_master;

    localparam int unsigned ADDR_W  = 8;
    localparam int unsigned TIMEOUT = 15;
    localparam int          BOUND   = 100;

    logic               clk = 1'b0;
    logic               rst;
    logic               core_req, core_we;
    logic [2:0]         core_funct3;
    logic [31:0]        core_addr, core_wdata;
    logic               busy, done, err;
    logic [31:0]        rdata;
    logic               mem_request, mem_we_re;
    logic [3:0]         mem_mask;
    logic [ADDR_W-1:0]  mem_address;
    logic [31:0]        mem_data_in;
    logic               mem_valid;
    logic [31:0]        mem_data_out;

    lsu_mem_master #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst          (rst),
        .core_req     (core_req),
        .core_we      (core_we),
        .core_funct3  (core_funct3),
        .core_addr    (core_addr),
        .core_wdata   (core_wdata),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .rdata        (rdata),
        .mem_request  (mem_request),
        .mem_we_re    (mem_we_re),
        .mem_mask     (mem_mask),
        .mem_address  (mem_address),
        .mem_data_in  (mem_data_in),
        .mem_valid    (mem_valid),
        .mem_data_out (mem_data_out)
    );

    always #5 clk = ~clk;

    // Memory model: registered response one cycle after a request.
    logic [31:0] mem [0:(1<<ADDR_W)-1];
    logic        resp_en     = 1'b1;
    logic        auto_valid  = 1'b0;
    logic        force_valid = 1'b0;
    logic [31:0] force_data  = '0;
    logic [31:0] rd_word     = '0;

    assign mem_valid    = auto_valid | force_valid;
    assign mem_data_out = force_valid ? force_data : rd_word;

    always @(posedge clk) begin
        auto_valid <= 1'b0;
        if (mem_request === 1'b1) begin
            if (mem_we_re) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_mask[b]) mem[mem_address][8*b +: 8] <= mem_data_in[8*b +: 8];
                end
            end
            rd_word    <= mem[mem_address];
            auto_valid <= resp_en;
        end
    end

    typedef struct {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_rdata = '0;

    int                r_lat, r_req_cyc, r_nreq;
    logic              r_err, r_busy_next, r_we;
    logic [31:0]       r_rdata, r_data;
    logic [3:0]        r_mask;
    logic [ADDR_W-1:0] r_addr;

    // Drive one access and record what the DUT did until done (bounded).
    task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd);
        @(negedge clk);
        core_req = 1'b1; core_we = we; core_funct3 = f3; core_addr = addr; core_wdata = wd;
        @(negedge clk);
        core_req = 1'b0;
        r_lat = 1; r_nreq = 0; r_req_cyc = 0;
        r_mask = '0; r_addr = '0; r_data = '0; r_we = 1'b0;
        while (done !== 1'b1 && r_lat < BOUND) begin
            if (mem_request === 1'b1) begin
                r_nreq++; r_req_cyc = r_lat;
                r_mask = mem_mask; r_addr = mem_address; r_data = mem_data_in; r_we = mem_we_re;
            end
            @(negedge clk);
            r_lat++;
        end
        r_err = err; r_rdata = rdata;
        @(negedge clk);
        r_busy_next = busy;
    endtask

    task automatic test_reset();
        rst = 1'b0; core_req = 1'b0; core_we = 1'b0; core_funct3 = '0;
        core_addr = '0; core_wdata = '0;
        repeat (3) @(negedge clk);
        checks++; if ({busy, done, err, mem_request, mem_we_re} !== 5'b0) begin errors++;
            $display("FAIL reset_ctrl: got %b expected 00000", {busy, done, err, mem_request, mem_we_re}); end
        checks++; if ({mem_mask, mem_address, mem_data_in, rdata} !== '0) begin errors++;
            $display("FAIL reset_data: got %h/%h/%h/%h expected zeros", mem_mask, mem_address, mem_data_in, rdata); end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_word();
        sb.push_back('{1'b0, last_rdata});
        access(1'b1, 3'd2, 32'h10, 32'hDEADBEEF);
        e = sb.pop_front();
        checks++; if (r_lat !== 3) begin errors++; $display("FAIL sw_latency: got %0d expected 3", r_lat); end
        checks++; if (r_req_cyc !== 1 || r_nreq !== 1) begin errors++;
            $display("FAIL sw_request: got cycle %0d count %0d expected cycle 1 count 1", r_req_cyc, r_nreq); end
        checks++; if ({r_we, r_mask, r_addr, r_data} !== {1'b1, 4'hF, 8'd4, 32'hDEADBEEF}) begin errors++;
            $display("FAIL sw_bus: got we %b mask %h addr %h data %h expected 1 f 04 deadbeef", r_we, r_mask, r_addr, r_data); end
        checks++; if (r_err !== e.err || r_rdata !== e.rdata) begin errors++;
            $display("FAIL sw_resp: got err %b rdata %h expected %b %h", r_err, r_rdata, e.err, e.rdata); end

        sb.push_back('{1'b0, 32'hDEADBEEF}); last_rdata = 32'hDEADBEEF;
        access(1'b0, 3'd2, 32'h10, 32'h0);
        e = sb.pop_front();
        checks++; if (r_lat !== 3) begin errors++; $display("FAIL lw_latency: got %0d expected 3", r_lat); end
        checks++; if ({r_we, r_mask, r_addr} !== {1'b0, 4'hF, 8'd4}) begin errors++;
            $display("FAIL lw_bus: got we %b mask %h addr %h expected 0 f 04", r_we, r_mask, r_addr); end
        checks++; if (r_err !== e.err || r_rdata !== e.rdata) begin errors++;
            $display("FAIL lw_resp: got err %b rdata %h expected %b %h", r_err, r_rdata, e.err, e.rdata); end
        checks++; if (r_busy_next !== 1'b0) begin errors++; $display("FAIL lw_busy_drop: got %b expected 0", r_busy_next); end
    endtask

    task automatic test_byte();
        sb.push_back('{1'b0, last_rdata});
        access(1'b1, 3'd0, 32'h13, 32'h000000A5);
        e = sb.pop_front();
        checks++; if ({r_mask, r_data} !== {4'b1000, 32'hA5A5A5A5}) begin errors++;
            $display("FAIL sb_bus: got mask %b data %h expected 1000 a5a5a5a5", r_mask, r_data); end
        checks++; if (r_rdata !== e.rdata || r_err !== e.err) begin errors++;
            $display("FAIL sb_resp: got err %b rdata %h expected %b %h", r_err, r_rdata, e.err, e.rdata); end

        sb.push_back('{1'b0, 32'hFFFFFFA5});
        sb.push_back('{1'b0, 32'h000000A5});
        access(1'b0, 3'd0, 32'h13, 32'h0);
        e = sb.pop_front();
        checks++; if (r_mask !== 4'b1000 || r_rdata !== e.rdata || r_err !== e.err) begin errors++;
            $display("FAIL lb: got mask %b rdata %h err %b expected 1000 %h %b", r_mask, r_rdata, r_err, e.rdata, e.err); end
        access(1'b0, 3'd4, 32'h13, 32'h0);
        e = sb.pop_front();
        checks++; if (r_rdata !== e.rdata || r_err !== e.err) begin errors++;
            $display("FAIL lbu: got rdata %h err %b expected %h %b", r_rdata, r_err, e.rdata, e.err); end
        last_rdata = 32'h000000A5;
    endtask

    task automatic test_half();
        sb.push_back('{1'b0, last_rdata});
        access(1'b1, 3'd1, 32'h22, 32'h00008001);
        e = sb.pop_front();
        checks++; if ({r_mask, r_addr, r_data} !== {4'b1100, 8'd8, 32'h80018001}) begin errors++;
            $display("FAIL sh_bus: got mask %b addr %h data %h expected 1100 08 80018001", r_mask, r_addr, r_data); end
        checks++; if (r_rdata !== e.rdata) begin errors++;
            $display("FAIL sh_rdata_hold: got %h expected %h", r_rdata, e.rdata); end

        sb.push_back('{1'b0, 32'hFFFF8001});
        sb.push_back('{1'b0, 32'h00008001});
        access(1'b0, 3'd1, 32'h22, 32'h0);
        e = sb.pop_front();
        checks++; if (r_rdata !== e.rdata || r_err !== e.err) begin errors++;
            $display("FAIL lh: got rdata %h err %b expected %h %b", r_rdata, r_err, e.rdata, e.err); end
        access(1'b0, 3'd5, 32'h22, 32'h0);
        e = sb.pop_front();
        checks++; if (r_rdata !== e.rdata || r_err !== e.err) begin errors++;
            $display("FAIL lhu: got rdata %h err %b expected %h %b", r_rdata, r_err, e.rdata, e.err); end
        last_rdata = 32'h00008001;
    endtask

    // Misaligned and illegal-funct3 accesses: no memory request, error one cycle after acceptance.
    task automatic test_misalign();
        logic        we_t [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [2:0]  f3_t [4] = '{3'd2, 3'd1, 3'd3, 3'd4};
        logic [31:0] ad_t [4] = '{32'h11, 32'h01, 32'h10, 32'h10};
        for (int i = 0; i < 4; i++) begin
            sb.push_back('{1'b1, last_rdata});
            access(we_t[i], f3_t[i], ad_t[i], 32'h12345678);
            e = sb.pop_front();
            checks++; if (r_nreq !== 0 || r_lat !== 1) begin errors++;
                $display("FAIL bad_access_%0d: got requests %0d latency %0d expected 0 1", i, r_nreq, r_lat); end
            checks++; if (r_err !== e.err || r_rdata !== e.rdata || r_busy_next !== 1'b0) begin errors++;
                $display("FAIL bad_resp_%0d: got err %b rdata %h busy %b expected %b %h 0", i, r_err, r_rdata, r_busy_next, e.err, e.rdata); end
        end
    endtask

    task automatic test_timeout();
        resp_en = 1'b0;
        sb.push_back('{1'b1, last_rdata});
        access(1'b0, 3'd2, 32'h10, 32'h0);
        e = sb.pop_front();
        checks++; if (r_req_cyc !== 1 || r_lat - r_req_cyc !== 17) begin errors++;
            $display("FAIL timeout_latency: got request cycle %0d done cycle %0d expected 1 18", r_req_cyc, r_lat); end
        checks++; if (r_err !== e.err || r_rdata !== e.rdata) begin errors++;
            $display("FAIL timeout_resp: got err %b rdata %h expected %b %h", r_err, r_rdata, e.err, e.rdata); end
        checks++; if (r_busy_next !== 1'b0) begin errors++; $display("FAIL timeout_busy: got %b expected 0", r_busy_next); end
        resp_en = 1'b1;
    endtask

    // core_req held high: second access accepted only in the IDLE cycle after RESP.
    task automatic test_back_to_back();
        int req_c[$];
        int done_c[$];
        @(negedge clk);
        core_req = 1'b1; core_we = 1'b0; core_funct3 = 3'd2; core_addr = 32'h10;
        sb.push_back('{1'b0, 32'hA5ADBEEF});
        sb.push_back('{1'b0, 32'hA5ADBEEF});
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            if (c == 5) core_req = 1'b0;
            if (mem_request === 1'b1) req_c.push_back(c);
            if (done === 1'b1) begin
                done_c.push_back(c);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    checks++; if (rdata !== e.rdata || err !== e.err) begin errors++;
                        $display("FAIL b2b_resp: got rdata %h err %b expected %h %b", rdata, err, e.rdata, e.err); end
                end
            end
        end
        checks++; if (req_c.size() !== 2 || req_c[0] !== 1 || req_c[1] !== 5) begin errors++;
            $display("FAIL b2b_requests: got %0d requests first %0d expected 2 at 1 and 5", req_c.size(), (req_c.size() > 0) ? req_c[0] : -1); end
        checks++; if (done_c.size() !== 2 || done_c[0] !== 3 || done_c[1] !== 7) begin errors++;
            $display("FAIL b2b_done: got %0d dones first %0d expected 2 at 3 and 7", done_c.size(), (done_c.size() > 0) ? done_c[0] : -1); end
        checks++; if (sb.size() !== 0) begin errors++; $display("FAIL b2b_drain: got %0d pending expected 0", sb.size()); sb.delete(); end
        last_rdata = 32'hA5ADBEEF;
    endtask

    // Reset during WAIT; a late response must be dropped and the next load must work.
    task automatic test_reset_mid();
        int seen_done;
        resp_en = 1'b0;
        @(negedge clk);
        core_req = 1'b1; core_we = 1'b0; core_funct3 = 3'd2; core_addr = 32'h10;
        @(negedge clk);
        core_req = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before: got %b expected 1", busy); end
        rst = 1'b0;
        #1;
        checks++; if ({busy, done, err, mem_request, mem_we_re, mem_mask, mem_address, mem_data_in, rdata} !== '0) begin errors++;
            $display("FAIL mid_reset_values: got busy %b mask %h addr %h data %h rdata %h expected zeros", busy, mem_mask, mem_address, mem_data_in, rdata); end
        @(negedge clk);
        rst = 1'b1; force_valid = 1'b1; force_data = 32'h12345678;
        @(negedge clk);
        force_valid = 1'b0;
        seen_done = 0;
        repeat (4) begin
            if (done === 1'b1 || busy === 1'b1) seen_done++;
            @(negedge clk);
        end
        checks++; if (seen_done !== 0 || rdata !== 32'h0) begin errors++;
            $display("FAIL mid_dropped: got %0d active cycles rdata %h expected 0 00000000", seen_done, rdata); end
        resp_en = 1'b1;
        sb.push_back('{1'b0, 32'hA5ADBEEF});
        access(1'b0, 3'd2, 32'h10, 32'h0);
        e = sb.pop_front();
        checks++; if (r_lat !== 3 || r_rdata !== e.rdata || r_err !== e.err) begin errors++;
            $display("FAIL mid_next_lw: got latency %0d rdata %h err %b expected 3 %h %b", r_lat, r_rdata, r_err, e.rdata, e.err); end
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_misalign();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
